// File: rtl/sram_rr_arbiter_pkg.sv
// Shared constants and helpers for the SRAM round-robin bank arbiter.
package sram_rr_arbiter_pkg;
  localparam int NUM_SRAMS       = 8;
  localparam int MAX_ADDR_WIDTH  = 12;
  localparam int SRAM_WIDTH_O    = 64;
  localparam int IDX_WIDTH       = 3;
  localparam int NUM_REQ_DEFAULT = 4;

  // Width of a requester index; never zero so a single requester still has a port.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Round-robin one-hot picker: first set request at or after the pointer, wrapping.
module sram_rr_arbiter_rr_pick
  import sram_rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_win,
  output logic          o_any
);
  always_comb begin
    o_gnt = '0;
    o_win = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        o_win      = PW'(idx);
        o_any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_rr_arbiter.sv
// Per-bank round-robin arbiter between NUM_REQ requesters and the SRAM banks,
// with routed 1-cycle read responses and conflict/grant statistics.
module sram_rr_arbiter #(
  parameter int NUM_REQ        = sram_rr_arbiter_pkg::NUM_REQ_DEFAULT,
  parameter int NUM_SRAMS      = sram_rr_arbiter_pkg::NUM_SRAMS,
  parameter int MAX_ADDR_WIDTH = sram_rr_arbiter_pkg::MAX_ADDR_WIDTH,
  parameter int DATA_WIDTH     = sram_rr_arbiter_pkg::SRAM_WIDTH_O,
  parameter int IDX_WIDTH      = sram_rr_arbiter_pkg::IDX_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0]                         i_req_valid,
  input  logic [NUM_REQ-1:0]                         i_req_we,
  input  logic [NUM_REQ-1:0][IDX_WIDTH-1:0]          i_req_idx,
  input  logic [NUM_REQ-1:0][MAX_ADDR_WIDTH-1:0]     i_req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]         i_req_wdata,
  output logic [NUM_REQ-1:0]                         o_req_ready,
  output logic [NUM_REQ-1:0]                         o_rsp_valid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]         o_rsp_data,
  output logic [NUM_REQ-1:0]                         o_req_err,
  output logic [NUM_SRAMS-1:0]                       o_sram_en,
  output logic [NUM_SRAMS-1:0]                       o_sram_we,
  output logic [NUM_SRAMS-1:0][MAX_ADDR_WIDTH-1:0]   o_sram_addr,
  output logic [NUM_SRAMS-1:0][DATA_WIDTH-1:0]       o_sram_wdata,
  input  logic [NUM_SRAMS-1:0][DATA_WIDTH-1:0]       i_sram_rdata,
  output logic [63:0]                                o_conflict_counts,
  output logic [NUM_REQ-1:0][31:0]                   o_grant_counts
);
  import sram_rr_arbiter_pkg::*;

  localparam int PW = ptr_w(NUM_REQ);
  localparam logic [IDX_WIDTH:0] NS_W = (IDX_WIDTH+1)'(NUM_SRAMS);

  logic [NUM_SRAMS-1:0][NUM_REQ-1:0] w_cand, w_gnt;
  logic [NUM_SRAMS-1:0][PW-1:0]      w_win, r_ptr;
  logic [NUM_SRAMS-1:0]              w_any;
  logic [NUM_REQ-1:0]                w_oor, w_ready, w_xfer;
  logic [NUM_REQ-1:0]                r_pend, r_err;
  logic [NUM_REQ-1:0][IDX_WIDTH-1:0] r_bank;
  logic [NUM_REQ-1:0][31:0]          r_gcnt;
  logic [63:0]                       r_conf, w_nconf;

  for (genvar b = 0; b < NUM_SRAMS; b++) begin : g_bank
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_cand
      assign w_cand[b][r] = i_req_valid[r] && (i_req_idx[r] == IDX_WIDTH'(b));
    end

    sram_rr_arbiter_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
      .i_req (w_cand[b]),
      .i_ptr (r_ptr[b]),
      .o_gnt (w_gnt[b]),
      .o_win (w_win[b]),
      .o_any (w_any[b])
    );

    assign o_sram_en[b]    = rst && w_any[b];
    assign o_sram_we[b]    = o_sram_en[b] && i_req_we[w_win[b]];
    assign o_sram_addr[b]  = o_sram_en[b] ? i_req_addr[w_win[b]]  : '0;
    assign o_sram_wdata[b] = o_sram_en[b] ? i_req_wdata[w_win[b]] : '0;
  end

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign w_oor[r]      = i_req_valid[r] && ({1'b0, i_req_idx[r]} >= NS_W);
    assign o_rsp_data[r] = r_pend[r] ? i_sram_rdata[r_bank[r]] : '0;
  end

  // Out-of-range requests are absorbed immediately so they cannot stall a requester.
  always_comb begin
    w_ready = w_oor;
    for (int b = 0; b < NUM_SRAMS; b++) w_ready = w_ready | w_gnt[b];
    if (!rst) w_ready = '0;
    w_xfer  = i_req_valid & w_ready;
    w_nconf = '0;
    for (int r = 0; r < NUM_REQ; r++)
      w_nconf = w_nconf + 64'(i_req_valid[r] && !w_ready[r]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr  <= '0;
      r_pend <= '0;
      r_err  <= '0;
      r_bank <= '0;
      r_gcnt <= '0;
      r_conf <= '0;
    end else begin
      for (int b = 0; b < NUM_SRAMS; b++)
        if (w_any[b])
          r_ptr[b] <= (w_win[b] == PW'(NUM_REQ-1)) ? '0 : w_win[b] + 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin
        r_pend[r] <= w_xfer[r] && !i_req_we[r] && !w_oor[r];
        r_err[r]  <= w_xfer[r] && w_oor[r];
        if (w_xfer[r]) begin
          r_gcnt[r] <= r_gcnt[r] + 32'd1;
          r_bank[r] <= i_req_idx[r];
        end
      end
      r_conf <= r_conf + w_nconf;
    end
  end

  // Responses are masked during reset so an in-flight read never surfaces.
  assign o_req_ready       = w_ready;
  assign o_rsp_valid       = r_pend & {NUM_REQ{rst}};
  assign o_req_err         = r_err & {NUM_REQ{rst}};
  assign o_conflict_counts = r_conf;
  assign o_grant_counts    = r_gcnt;
endmodule
